// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver with first-word-fall-through scan code FIFO
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 1600
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  CLK_en,
  input  logic                  PS2_CLK,
  input  logic                  PS2_DATA,
  input  logic                  READ,
  output logic [7:0]            DATA_OUT,
  output logic                  VALID,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  PARITY_ERR,
  output logic                  FRAME_ERR,
  output logic                  OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Two-flop synchronisers for the asynchronous pins
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  // Deglitched PS/2 clock
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          w_filt_take;
  logic          w_fall;

  // Frame decoder
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          r_parity_err;
  logic          r_frame_err;
  logic          w_push;

  // FIFO storage
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  w_full, w_rd, w_wr;

  // Bring both PS/2 pins into the CLK domain
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2_DATA;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample
  assign w_filt_take = (r_clk_s2 != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_fall      = CLK_en && w_filt_take && r_filt_clk;

  // Count consecutive samples that disagree with the filtered level
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (CLK_en) begin
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (w_filt_take) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // A good frame is pushed in the same cycle its stop bit is sampled
  assign w_push = w_fall && (r_state == S_STOP) && r_dat_s2 && (^{r_shift, r_par});

  // Edge-driven frame decoder with mid-frame timeout and registered error pulses
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_tmo        <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (CLK_en) begin
        if (w_fall) begin
          r_tmo <= '0;
          case (r_state)
            S_IDLE: begin
              if (!r_dat_s2) begin
                r_state   <= S_DATA;
                r_bit_cnt <= '0;
              end
            end
            S_DATA: begin
              r_shift   <= {r_dat_s2, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
            end
            S_PARITY: begin
              r_par   <= r_dat_s2;
              r_state <= S_STOP;
            end
            S_STOP: begin
              if (!r_dat_s2) r_frame_err <= 1'b1;
              else if (!(^{r_shift, r_par})) r_parity_err <= 1'b1;
              r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end else if (r_state == S_IDLE) begin
          r_tmo <= '0;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_frame_err <= 1'b1;
          r_state     <= S_IDLE;
          r_tmo       <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end

  // A read frees the head slot, so a push into a full FIFO is accepted alongside it
  assign w_full = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign w_rd   = READ && (r_count != '0);
  assign w_wr   = w_push && (!w_full || w_rd);

  // Circular buffer pointers, occupancy and sticky overflow
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_rd) r_overflow <= 1'b1;
    end
  end

  assign DATA_OUT   = r_mem[r_rptr];
  assign VALID      = (r_count != '0);
  assign COUNT      = r_count;
  assign PARITY_ERR = r_parity_err;
  assign FRAME_ERR  = r_frame_err;
  assign OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  logic       CLK = 1'b0;
  logic       nRESET, CLK_en, PS2_CLK, PS2_DATA, READ;
  logic [7:0] DATA_OUT;
  logic       VALID, PARITY_ERR, FRAME_ERR, OVERFLOW;
  logic [3:0] COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_data[$];
  int         exp_evt[$];   // 1 = parity error, 2 = frame error

  ps2_rx_fifo #(.DEPTH_LOG2(3), .FILTER_LEN(4), .TIMEOUT(1600)) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_en(CLK_en), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .READ(READ), .DATA_OUT(DATA_OUT), .VALID(VALID), .COUNT(COUNT),
    .PARITY_ERR(PARITY_ERR), .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Sample enable: one CLK cycle in six
  initial begin
    CLK_en = 1'b0;
    forever begin
      repeat (5) @(posedge CLK);
      #1 CLK_en = 1'b1;
      @(posedge CLK);
      #1 CLK_en = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive n bits of seq LSB first; glitch >= 0 pulses PS2_CLK low for 2 ticks during that bit
  task automatic send_seq(input logic [10:0] seq, input int n, input int glitch);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = seq[i];
      if (i == glitch) begin
        cyc(20); PS2_CLK = 1'b0; cyc(12); PS2_CLK = 1'b1; cyc(28);
      end else begin
        cyc(60);
      end
      PS2_CLK = 1'b0;
      cyc(60);
      PS2_CLK = 1'b1;
    end
    cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int glitch);
    send_seq({stop, par, b, 1'b0}, 11, glitch);
  endtask

  task automatic read_one();
    int t = 0;
    while (!VALID && t < 200) begin cyc(1); t++; end
    if (!VALID) chk("read_wait_valid", VALID, 1);
    else begin
      READ = 1'b1;
      cyc(1);
      READ = 1'b0;
    end
  endtask

  // Monitor: compare popped bytes and error pulses against the expectation queues
  always @(negedge CLK) begin
    if (nRESET) begin
      if (READ && VALID) begin
        if (exp_data.size() == 0) chk("unexpected_read", DATA_OUT, 8'hxx);
        else chk("read_data", DATA_OUT, exp_data.pop_front());
      end
      if (PARITY_ERR) begin
        if (exp_evt.size() == 0) chk("unexpected_parity_err", 1, 0);
        else chk("parity_err_event", 1, exp_evt.pop_front());
      end
      if (FRAME_ERR) begin
        if (exp_evt.size() == 0) chk("unexpected_frame_err", 2, 0);
        else chk("frame_err_event", 2, exp_evt.pop_front());
      end
    end
  end

  initial begin
    nRESET = 1'b0; PS2_CLK = 1'b1; PS2_DATA = 1'b1; READ = 1'b0;
    cyc(10);
    chk("rst_valid", VALID, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_overflow", OVERFLOW, 0);
    nRESET = 1'b1;
    cyc(20);

    // Single good frame
    exp_data.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    chk("t1_valid", VALID, 1);
    chk("t1_count", COUNT, 1);
    chk("t1_data", DATA_OUT, 8'h1C);
    read_one();
    chk("t1_valid_after_read", VALID, 0);
    chk("t1_count_after_read", COUNT, 0);

    // Bad then good parity
    exp_evt.push_back(1);
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    chk("t2_count_bad_parity", COUNT, 0);
    chk("t2_evt_seen", exp_evt.size(), 0);
    exp_data.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    chk("t2_data", DATA_OUT, 8'hF0);
    read_one();

    // Bad stop bit
    exp_evt.push_back(2);
    send_frame(8'h29, 1'b0, 1'b0, -1);
    chk("t3_count", COUNT, 0);
    chk("t3_evt_seen", exp_evt.size(), 0);

    // Overflow: nine frames into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      logic [7:0] b;
      b = 8'(i);
      if (i <= 8) exp_data.push_back(b);
      send_frame(b, ~^b, 1'b1, -1);
    end
    chk("t4_count_full", COUNT, 8);
    chk("t4_overflow", OVERFLOW, 1);
    chk("t4_head", DATA_OUT, 8'h01);
    repeat (8) read_one();
    chk("t4_valid_empty", VALID, 0);
    chk("t4_overflow_sticky", OVERFLOW, 1);

    // Mid-frame timeout, then recovery
    exp_evt.push_back(2);
    send_seq(11'b000_0000_1101 << 1, 5, -1);
    cyc(1700 * 6);
    chk("t5_evt_seen", exp_evt.size(), 0);
    chk("t5_count", COUNT, 0);
    exp_data.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    chk("t5_data", DATA_OUT, 8'h5A);
    read_one();

    // Short PS2_CLK glitch inside a frame
    exp_data.push_back(8'h77);
    send_frame(8'h77, 1'b1, 1'b1, 3);
    chk("t6_glitch_count", COUNT, 1);
    read_one();

    // Reset mid-frame with a byte held in the FIFO
    send_frame(8'h33, 1'b1, 1'b1, -1);
    send_seq(11'b000_0000_0110, 4, -1);
    nRESET = 1'b0;
    exp_data.delete();
    cyc(3);
    chk("t6_rst_valid", VALID, 0);
    chk("t6_rst_count", COUNT, 0);
    chk("t6_rst_data", DATA_OUT, 0);
    chk("t6_rst_overflow", OVERFLOW, 0);
    chk("t6_rst_errs", {PARITY_ERR, FRAME_ERR}, 0);
    nRESET = 1'b1;
    cyc(20);
    exp_data.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    chk("t6_after_rst_count", COUNT, 1);
    read_one();

    cyc(10);
    chk("final_data_queue_empty", exp_data.size(), 0);
    chk("final_evt_queue_empty", exp_evt.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
